// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants for the front end
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and synchronous flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk)
    !(push && !flush && (count_q == CW'(DEPTH)) && !do_pop))
    else $error("sync_fifo: push into full FIFO");
`endif
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, in-order imem requests, prefetch queue, redirect flush
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP      = NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic              alive_q;
  logic [CW-1:0]     q_count, pc_count;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0]   inflight_pc;
  logic [CW+1:0]     reserved;
  logic              req_fire, rsp_take, q_push, q_pop;

  // Slots already promised: queued words plus live (non-discarded) in-flight requests.
  always_comb begin
    reserved       = (CW+2)'(q_count) + (CW+2)'(outstanding_q) - (CW+2)'(discard_q);
    imem_req_valid = alive_q && enable && !redirect && (reserved < (CW+2)'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    q_push         = rsp_take && (discard_q == '0) && !redirect;
    q_pop          = (q_count != '0) && !stall && enable && !redirect;

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    if (rsp_take && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_target);
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      alive_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      alive_q       <= 1'b1;
    end
  end

  assign imem_req_addr = fetch_pc_q;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_take),
    .head_data (inflight_pc),
    .count     (pc_count)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_prefetch_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (q_push),
    .push_data ({inflight_pc, imem_rsp_data}),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count)
  );

  assign inst_valid = (q_count != '0);
  assign inst       = inst_valid ? q_head[XLEN-1:0] : NOP;
  assign inst_pc    = inst_valid ? q_head[2*XLEN-1:XLEN] : '0;

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge clk) imem_rsp_valid |-> (outstanding_q != '0))
    else $warning("fetch_unit: response with nothing outstanding dropped");
  a_pc_track: assert property (@(posedge clk) pc_count == outstanding_q)
    else $error("fetch_unit: in-flight PC FIFO out of step with outstanding count");
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register.
- Owns the program counter and issues in-order requests on a ready/valid instruction-memory bus.
- Buffers returned words with their PCs in a small prefetch queue and presents one instruction per cycle downstream.
- Handles stalls from the hazard unit and redirects (taken branch, jal, jalr) by flushing and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, value driven on inst when queue empty (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global run enable; low = no new requests, no pops.
- stall  in  1  downstream cannot accept (hazard unit, ~IFIDWrite).
- redirect  in  1  PC redirect request from ID stage.
- redirect_target  in  32  new fetch address; bits[1:0] ignored (forced 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid; responses return in request order, latency ≥1 cycle, never back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst  out  32  head instruction; NOP when empty.
- inst_pc  out  32  PC of head instruction; 0 when empty.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0; outputs imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=0.
- Counters outstanding and discard are $clog2(DEPTH)+1 bits. Queue holds {pc,instr}, head/tail pointers wrap modulo DEPTH.
- Request: imem_req_valid = enable & ~redirect & (count + outstanding - discard < DEPTH), with outstanding counting all in-flight requests. imem_req_addr = fetch_pc.
  - Handshake (valid & ready): fetch_pc += 4 (wraps at 2^32), outstanding += 1. PC sent with request pushed into a side FIFO of depth DEPTH, popped on response.
- Response (imem_rsp_valid): outstanding -= 1.
  - If discard>0: discard -= 1, word dropped.
  - Else: {pc,word} pushed to queue tail.
  - Slot reservation guarantees no overflow; an overflow attempt is an assertion failure.
- Output/pop: inst_valid = count>0. Pop when inst_valid & ~stall & enable. Response-to-inst_valid latency = 1 cycle; no bypass from rsp to output.
- Redirect (registered effect, next edge):
  - Queue cleared.
  - fetch_pc = {redirect_target[31:2],2'b00}.
  - discard = outstanding after this cycle's request/response accounting. A handshake is impossible in a redirect cycle; a response arriving in the same cycle is dropped and not added to discard.
  - Redirect overrides stall, pop and enable.
  - inst_valid=0 the cycle after redirect.
- Simultaneous push and pop with count==DEPTH is impossible by reservation. Push and pop on the same edge keeps count unchanged.
- enable low: no requests or pops; responses still accepted and queued/discarded.
- Reset asserted mid-transaction: all state cleared immediately. Late responses after reset release are ignored because outstanding==0 (responses with outstanding==0 are dropped, assertion warns).
- Request withdrawal only occurs via redirect or enable low; the memory tolerates valid dropping without ready.

Decomposition:
- Shared package rv32i_pkg: NOP constant, XLEN=32, opcode constants.
- One natural sub-module: sync_fifo (parameterised width/depth, count output), instantiated twice: prefetch queue (64-bit) and in-flight PC FIFO (32-bit).

Test Plan:
- Reset release, ready=1, 1-cycle response latency, no stall → requests 0,4,8,12…; inst_valid from cycle 3; inst_pc sequence 0,4,8 with matching words, one per cycle.
- Hold stall=1 with DEPTH=4 → exactly 4 queue entries plus 0 extra in-flight; imem_req_valid drops to 0; release stall → 4 in-order pops, fetch resumes at 16.
- Redirect to 0x100 with 2 requests outstanding (latency 3) → next two responses dropped; first inst_valid carries inst_pc=0x100; no stale PC ever presented.
- Redirect in the same cycle as a response and with stall=1 → response dropped, queue empties, fetch_pc=0x200 for target 0x203.
- enable=0 for 5 cycles with responses pending → responses queued, no new requests, no pops; enable=1 resumes with correct order.
- Assert rst mid-stream with outstanding=2 → outputs immediately at reset values; after release fetch restarts at RESET_PC.
